// File: rtl/wb_commit_arbiter.sv
// Writeback commit stage: merges ALU and buffered LSU results onto the single
// register file write port, with WAW ordering, x0 filtering and forwarding.
module wb_commit_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            rf_regwrite,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [4:0]      fwd_rs1,
  input  logic [4:0]      fwd_rs2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2,
  output logic            busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] fifo_live;
  logic [4:0]       fifo_rd   [DEPTH];
  logic [XLEN-1:0]  fifo_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic fifo_empty;
  logic alu_issue;
  logic pop;
  logic enq;
  logic enq_live;

  assign fifo_empty = (count == '0);
  assign lsu_ready  = !reset && (count < CNT_W'(DEPTH));
  assign alu_issue  = alu_valid && (alu_rd != 5'd0);
  // The ALU always owns the write slot when valid, even for x0.
  assign pop        = !alu_valid && !fifo_empty;
  // An x0 LSU result completes its handshake but is never stored.
  assign enq        = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
  // A same-cycle LSU result is older than the ALU one, so it arrives already dead.
  assign enq_live   = !(alu_issue && (alu_rd == lsu_rd));
  assign busy       = !fifo_empty || rf_regwrite;

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_regwrite <= 1'b0;
      rf_rd       <= '0;
      rf_wdata    <= '0;
    end else if (alu_valid) begin
      rf_regwrite <= alu_issue;
      rf_rd       <= alu_issue ? alu_rd : 5'd0;
      rf_wdata    <= alu_issue ? alu_data : '0;
    end else if (pop && fifo_live[rd_ptr]) begin
      rf_regwrite <= 1'b1;
      rf_rd       <= fifo_rd[rd_ptr];
      rf_wdata    <= fifo_data[rd_ptr];
    end else begin
      rf_regwrite <= 1'b0;
      rf_rd       <= '0;
      rf_wdata    <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_live <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_issue && (fifo_rd[i] == alu_rd)) begin
          fifo_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        fifo_live[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end
      if (enq) begin
        fifo_live[wr_ptr] <= enq_live;
        fifo_rd[wr_ptr]   <= lsu_rd;
        fifo_data[wr_ptr] <= lsu_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(enq) - CNT_W'(pop);
    end
  end

  // Scan oldest to newest so newer live FIFO entries override older ones and the output stage.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = '0;
    if (rf_regwrite && (fwd_rs1 != 5'd0) && (rf_rd == fwd_rs1)) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = rf_wdata;
    end
    if (rf_regwrite && (fwd_rs2 != 5'd0) && (rf_rd == fwd_rs2)) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = rf_wdata;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && fifo_live[idx]) begin
        if ((fwd_rs1 != 5'd0) && (fifo_rd[idx] == fwd_rs1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = fifo_data[idx];
        end
        if ((fwd_rs2 != 5'd0) && (fifo_rd[idx] == fwd_rs2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = fifo_data[idx];
        end
      end
    end
  end

endmodule
